// File: rtl/draw_pkg.sv
// Shared types and default geometry for the draw command engine.
package draw_pkg;

  localparam int unsigned FB_W_DEF       = 160;
  localparam int unsigned FB_H_DEF       = 120;
  localparam int unsigned XW_DEF         = 8;
  localparam int unsigned YW_DEF         = 7;
  localparam int unsigned CW_DEF         = 3;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned CMD_W          = 16;
  localparam int unsigned ADDR_W         = $clog2(FB_W_DEF * FB_H_DEF);

  typedef enum logic [1:0] {
    OP_SPAN  = 2'b00,
    OP_RECT  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG1,
    S_ARG2,
    S_SETUP,
    S_DRAW
  } state_e;

endpackage

// File: rtl/draw_cmd_engine_if.sv
// Command write port and framebuffer pixel port of the draw engine.
interface draw_cmd_engine_if #(
  parameter int unsigned AW = draw_pkg::ADDR_W,
  parameter int unsigned CW = draw_pkg::CW_DEF
) ();

  logic          we;
  logic [15:0]   data;
  logic          full;
  logic          overflow;
  logic          busy;
  logic          fb_we;
  logic          fb_ready;
  logic [AW-1:0] fb_addr;
  logic [CW-1:0] fb_data;

  // master: CPU store path plus framebuffer RAM; slave: the engine
  modport master (
    output we, data, fb_ready,
    input  full, overflow, busy, fb_we, fb_addr, fb_data
  );

  modport slave (
    input  we, data, fb_ready,
    output full, overflow, busy, fb_we, fb_addr, fb_data
  );

endinterface

// File: rtl/draw_cmd_fifo.sv
// Synchronous show-ahead FIFO for command words.
module draw_cmd_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             push_c, pop_c;

  assign full_o    = (count_q == CNTW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_c    = push_i & ~full_o;
  assign pop_c     = pop_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CNTW'(push_c) - CNTW'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/draw_cmd_engine.sv
// Draw command engine: fetches span/rect/clear commands from the FIFO,
// sorts and clips them, then streams one pixel write per accepted cycle.
module draw_cmd_engine
  import draw_pkg::*;
#(
  parameter int unsigned FB_W       = FB_W_DEF,
  parameter int unsigned FB_H       = FB_H_DEF,
  parameter int unsigned XW         = XW_DEF,
  parameter int unsigned YW         = YW_DEF,
  parameter int unsigned CW         = CW_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  draw_cmd_engine_if.slave  bus
);

  localparam int unsigned AW = $clog2(FB_W * FB_H);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [CW-1:0] col_q, col_d;
  logic [XW-1:0] x0_q, x0_d, x1_q, x1_d, x_q, x_d;
  logic [YW-1:0] y0_q, y0_d, y1_q, y1_d, y_q, y_d;
  logic [AW-1:0] rowbase_q, rowbase_d;
  logic [AW-1:0] fb_addr_q, fb_addr_d;
  logic [CW-1:0] fb_data_q, fb_data_d;
  logic          fb_we_q, fb_we_d;
  logic          overflow_q, overflow_d;

  logic              full_c, empty_c, pop_c;
  logic [CMD_W-1:0]  fifo_rd;
  logic              unused_rd_c;

  logic [XW-1:0] lo_x_c, hi_x_c;
  logic [YW-1:0] lo_y_c, hi_y_c, y1_raw_c;
  logic [AW-1:0] rowbase_c;
  logic          off_c;

  draw_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (bus.we),
    .wr_data_i (bus.data),
    .pop_i     (pop_c),
    .rd_data_o (fifo_rd),
    .full_o    (full_c),
    .empty_o   (empty_c)
  );

  // Pad bits of the command words are ignored.
  assign unused_rd_c = ^fifo_rd;

  assign bus.full     = full_c;
  assign bus.overflow = overflow_q;
  assign bus.busy     = ~empty_c | (state_q != S_IDLE);
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;

  // Sorted and clipped extents, consumed only in SETUP.
  always_comb begin
    y1_raw_c = (op_q == OP_RECT) ? y1_q : y0_q;
    lo_x_c   = (x0_q > x1_q) ? x1_q : x0_q;
    hi_x_c   = (x0_q > x1_q) ? x0_q : x1_q;
    lo_y_c   = (y0_q > y1_raw_c) ? y1_raw_c : y0_q;
    hi_y_c   = (y0_q > y1_raw_c) ? y0_q : y1_raw_c;
    if (32'(hi_x_c) > FB_W - 1) hi_x_c = XW'(FB_W - 1);
    if (32'(hi_y_c) > FB_H - 1) hi_y_c = YW'(FB_H - 1);
    if (op_q == OP_CLEAR) begin
      lo_x_c = '0;
      hi_x_c = XW'(FB_W - 1);
      lo_y_c = '0;
      hi_y_c = YW'(FB_H - 1);
    end
    off_c     = (32'(lo_x_c) >= FB_W) || (32'(lo_y_c) >= FB_H);
    rowbase_c = AW'(32'(lo_y_c) * FB_W);
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    col_d      = col_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    x_d        = x_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    y_d        = y_q;
    rowbase_d  = rowbase_q;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    fb_we_d    = fb_we_q;
    pop_c      = 1'b0;
    overflow_d = overflow_q | (bus.we & full_c);

    unique case (state_q)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c = 1'b1;
          op_d  = op_e'(fifo_rd[15:14]);
          y0_d  = fifo_rd[YW+CW-1:CW];
          col_d = fifo_rd[CW-1:0];
          unique case (op_e'(fifo_rd[15:14]))
            OP_SPAN, OP_RECT: state_d = S_ARG1;
            OP_CLEAR:         state_d = S_SETUP;
            default:          state_d = S_IDLE;
          endcase
        end
      end
      S_ARG1: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          x0_d    = XW'(fifo_rd[15:8]);
          x1_d    = XW'(fifo_rd[7:0]);
          state_d = (op_q == OP_RECT) ? S_ARG2 : S_SETUP;
        end
      end
      S_ARG2: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          y1_d    = fifo_rd[YW-1:0];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (off_c) begin
          state_d = S_IDLE;
        end else begin
          x0_d      = lo_x_c;
          x1_d      = hi_x_c;
          y1_d      = hi_y_c;
          x_d       = lo_x_c;
          y_d       = lo_y_c;
          rowbase_d = rowbase_c;
          fb_addr_d = rowbase_c + AW'(lo_x_c);
          fb_data_d = col_q;
          fb_we_d   = 1'b1;
          state_d   = S_DRAW;
        end
      end
      S_DRAW: begin
        if (bus.fb_ready) begin
          if (x_q == x1_q) begin
            if (y_q == y1_q) begin
              fb_we_d = 1'b0;
              state_d = S_IDLE;
            end else begin
              x_d       = x0_q;
              y_d       = y_q + YW'(1);
              rowbase_d = rowbase_q + AW'(FB_W);
              fb_addr_d = rowbase_q + AW'(FB_W) + AW'(x0_q);
            end
          end else begin
            x_d       = x_q + XW'(1);
            fb_addr_d = fb_addr_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      col_q      <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      x_q        <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      y_q        <= '0;
      rowbase_q  <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      fb_we_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      col_q      <= col_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      x_q        <= x_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      y_q        <= y_d;
      rowbase_q  <= rowbase_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_we_q    <= fb_we_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_draw_cmd_engine.sv
// Directed bench for draw_cmd_engine with a pixel scoreboard.
module tb_draw_cmd_engine;

  typedef struct {
    int addr;
    int data;
  } pix_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   rise_cyc = 0;
  int   last_cyc = 0;
  logic fb_we_prev = 1'b0;
  pix_t exp_q[$];

  draw_cmd_engine_if #(.AW(15), .CW(3)) ifc ();

  draw_cmd_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pixel monitor: each accepted write must match the next expected pixel.
  always @(negedge clk) begin
    pix_t e;
    if (!reset && ifc.fb_we) begin
      if (!fb_we_prev) rise_cyc = cyc;
      if (ifc.fb_ready) begin
        last_cyc = cyc;
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("pix_unexpected", 32'(ifc.fb_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pix_addr", 32'(ifc.fb_addr), e.addr);
          check("pix_data", 32'(ifc.fb_data), e.data);
        end
      end
    end
    fb_we_prev = reset ? 1'b0 : ifc.fb_we;
  end

  task automatic push_box(input int x0, input int x1, input int y0, input int y1, input int c);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        pix_t p;
        p.addr = y * 160 + x;
        p.data = c;
        exp_q.push_back(p);
      end
  endtask

  task automatic write_word(input logic [15:0] w);
    ifc.we   = 1'b1;
    ifc.data = w;
    @(posedge clk);
    #1;
    ifc.we   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && (ifc.busy || ifc.fb_we); i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 32'(ifc.busy), 32'd0);
  endtask

  task automatic wait_wr(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && wr_cnt < n; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 32'(wr_cnt >= n), 32'd1);
  endtask

  initial begin
    int base;
    int t0;
    logic [31:0] hold_addr, hold_data;

    reset        = 1'b1;
    ifc.we       = 1'b0;
    ifc.data     = '0;
    ifc.fb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_we", 32'(ifc.fb_we), 0);
    check("rst_fb_addr", 32'(ifc.fb_addr), 0);
    check("rst_fb_data", 32'(ifc.fb_data), 0);
    check("rst_full", 32'(ifc.full), 0);
    check("rst_overflow", 32'(ifc.overflow), 0);
    check("rst_busy", 32'(ifc.busy), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic span, then the same span with reversed endpoints.
    for (int pass = 0; pass < 2; pass++) begin
      base = wr_cnt;
      push_box(10, 12, 5, 5, 3);
      write_word(16'h002B);
      t0 = cyc;
      write_word(pass == 0 ? 16'h0A0C : 16'h0C0A);
      wait_idle("span_idle", 50);
      check("span_cnt", wr_cnt - base, 3);
      check("span_lat", rise_cyc - t0, 3);
      check("span_burst", last_cyc - rise_cyc, 2);
      check("span_left", exp_q.size(), 0);
    end

    // Right-edge clip on the bottom row.
    base = wr_cnt;
    push_box(150, 159, 119, 119, 1);
    write_word(16'h03B9);
    write_word(16'h96C8);
    wait_idle("clip_idle", 60);
    check("clip_cnt", wr_cnt - base, 10);
    check("clip_left", exp_q.size(), 0);

    // Fully off-screen span produces nothing.
    base = wr_cnt;
    write_word(16'h03B9);
    write_word(16'hAAB4);
    wait_idle("off_idle", 30);
    check("off_cnt", wr_cnt - base, 0);

    // Rectangle, two rows.
    base = wr_cnt;
    push_box(0, 1, 2, 3, 7);
    write_word(16'h4017);
    t0 = cyc;
    write_word(16'h0001);
    write_word(16'h0003);
    wait_idle("rect_idle", 50);
    check("rect_cnt", wr_cnt - base, 4);
    check("rect_lat", rise_cyc - t0, 4);
    check("rect_left", exp_q.size(), 0);

    // Backpressure mid-span: outputs freeze, nothing lost or repeated.
    base = wr_cnt;
    push_box(0, 16, 5, 5, 3);
    write_word(16'h002B);
    write_word(16'h0010);
    wait_wr("bp_start", base + 3, 40);
    ifc.fb_ready = 1'b0;
    hold_addr = 32'(ifc.fb_addr);
    hold_data = 32'(ifc.fb_data);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_addr", 32'(ifc.fb_addr), hold_addr);
      check("bp_data", 32'(ifc.fb_data), hold_data);
      check("bp_we", 32'(ifc.fb_we), 1);
    end
    ifc.fb_ready = 1'b1;
    wait_idle("bp_idle", 60);
    check("bp_cnt", wr_cnt - base, 17);
    check("bp_left", exp_q.size(), 0);

    // FIFO fill while the draw is stalled; the ninth word must be dropped.
    ifc.fb_ready = 1'b0;
    push_box(10, 12, 5, 5, 3);
    write_word(16'h002B);
    write_word(16'h0A0C);
    for (int i = 0; i < 20 && !ifc.fb_we; i++) begin
      @(posedge clk);
      #1;
    end
    check("ovf_draw", 32'(ifc.fb_we), 1);
    for (int i = 0; i < 8; i++) begin
      write_word(16'hC000);
      if (i == 6) check("ovf_full7", 32'(ifc.full), 0);
    end
    check("ovf_full8", 32'(ifc.full), 1);
    check("ovf_pre", 32'(ifc.overflow), 0);
    write_word(16'h002B);
    check("ovf_set", 32'(ifc.overflow), 1);
    check("ovf_full9", 32'(ifc.full), 1);
    ifc.fb_ready = 1'b1;
    wait_idle("ovf_idle", 60);
    check("ovf_sticky", 32'(ifc.overflow), 1);
    check("ovf_left", exp_q.size(), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ovf_rst", 32'(ifc.overflow), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Clear, aborted by reset part-way through.
    base = wr_cnt;
    push_box(0, 159, 0, 119, 5);
    write_word(16'h8005);
    t0 = cyc;
    wait_wr("clr_start", base + 20, 100);
    check("clr_lat", rise_cyc - t0, 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("clr_rst_we", 32'(ifc.fb_we), 0);
    check("clr_rst_addr", 32'(ifc.fb_addr), 0);
    check("clr_rst_data", 32'(ifc.fb_data), 0);
    check("clr_rst_busy", 32'(ifc.busy), 0);
    exp_q.delete();
    reset = 1'b0;
    base = wr_cnt;
    repeat (30) @(posedge clk);
    #1;
    check("clr_quiet", wr_cnt - base, 0);
    check("clr_busy", 32'(ifc.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/draw_cmd_engine.md
Name: draw_cmd_engine

Overview:
Single-clock, parametrised successor to the painter draw unit. It accepts packed 16-bit draw commands through a buffered write port with a full flag. It decodes span, rectangle and clear commands with clipping and endpoint swapping, and emits one framebuffer pixel write per cycle over a valid/ready port. It sits between the CPU store path and the framebuffer RAM; VGA scan-out is outside this block.

Parameters:
FB_W, 160, framebuffer width in pixels
FB_H, 120, framebuffer height in pixels
XW, 8, x coordinate width (XW<=8)
YW, 7, y coordinate width (2+YW+CW<=16)
CW, 3, colour width in bits
FIFO_DEPTH, 8, command word FIFO depth (power of 2, >=4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
we  in  1  command word write strobe
data  in  16  command word
full  out  1  FIFO holds FIFO_DEPTH words
overflow  out  1  sticky: a write was dropped while full
busy  out  1  FIFO non-empty or FSM not IDLE
fb_we  out  1  pixel write valid
fb_ready  in  1  framebuffer accepts the pixel this cycle
fb_addr  out  clog2(FB_W*FB_H)  linear address y*FB_W+x
fb_data  out  CW  pixel colour

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: full=0, overflow=0, busy=0, fb_we=0, fb_addr=0, fb_data=0. FIFO is emptied and the FSM goes to IDLE.
- Reset mid-draw aborts the current command and discards all queued words.
- Command format:
  - word0 = {op[15:14], pad, y0[YW+CW-1:CW], colour[CW-1:0]}. op: 00 span, 01 rect, 10 clear, 11 nop.
  - span: word1 = {x0[15:8], x1[7:0]}.
  - rect: word1 as span, then word2 = {pad, y1[YW-1:0]}.
  - clear and nop are one word only.
- FIFO:
  - A write occurs when we=1 and full=0. A write while full is dropped and sets overflow, which holds until reset. A pop in the same cycle does not rescue a write made while full.
  - Write and pop in the same cycle when not full: count unchanged.
  - full is derived from the registered count.
- FSM states: IDLE, ARG1, ARG2, SETUP, DRAW.
  - IDLE: if the FIFO is non-empty, pop word0 and latch op, y0 and colour. span/rect go to ARG1; clear goes to SETUP; nop stays in IDLE.
  - ARG1: wait while the FIFO is empty, then pop word1. rect goes to ARG2; span goes to SETUP.
  - ARG2: wait while empty, then pop word2, then go to SETUP.
- SETUP (one cycle):
  - Swap x0/x1 if x0>x1, and y0/y1 if y0>y1 (span: y1=y0).
  - Clip x1 to FB_W-1 and y1 to FB_H-1.
  - If x0>=FB_W or y0>=FB_H, return to IDLE with no writes.
  - clear sets x 0..FB_W-1, y 0..FB_H-1.
  - Compute the row base y0*FB_W.
- DRAW:
  - fb_we=1 with fb_addr=rowbase+x. A pixel transfers when fb_we and fb_ready.
  - fb_addr and fb_data hold stable while fb_ready=0.
  - After an accepted pixel, x increments; at x1, x resets to x0, y increments and rowbase += FB_W. After the last pixel, go to IDLE with fb_we=0.
  - Pixel order is row-major, ascending.
- Timing (words preloaded, FSM in IDLE at cycle 0, fb_ready=1):
  - span: first fb_we in cycle 3; pixels in consecutive cycles.
  - rect: first fb_we in cycle 4.
  - clear: first fb_we in cycle 2.
  - Back-to-back commands incur the same fetch/setup bubbles.
- The FIFO keeps accepting writes during DRAW.

Decomposition:
- Shared package draw_pkg: opcode constants, FSM state encoding, and localparam ADDR_W=clog2(FB_W*FB_H).
- One sub-module, draw_cmd_fifo (synchronous FIFO: count, full, empty, show-ahead read), parametrised by width 16 and FIFO_DEPTH.

Test Plan:
- span 0x002B, 0x0A0C (y=5, c=3, x 10..12) -> fb_addr 810, 811, 812 in cycles 3-5 with fb_data=3; then busy=0. Reversed word1 0x0C0A -> identical writes.
- Clip: 0x03B9, 0x96C8 (y=119, x 150..200, c=1) -> exactly 10 writes, addr 19190..19199. Command with x0=170 -> no writes, returns to IDLE.
- rect 0x4017, 0x0001, 0x0003 (y 2..3, x 0..1, c=7) -> addr 320, 321, 480, 481 in order.
- Backpressure: drop fb_ready for 5 cycles mid-span -> fb_addr/fb_data frozen; every pixel accepted exactly once.
- Full/overflow: fb_ready=0 with a span in DRAW, write 9 further words -> full=1 after the 8th, 9th dropped, overflow=1 until reset.
- clear 0x8005 then assert reset mid-draw -> writes addr 0..k with data 5, then all outputs return to reset values next cycle and no further writes.
